// File: rtl/image_feeder_l2.sv
// Layer-2 image feeder: reads a ROWS x ROW_WORDS window from feature memory and
// pushes each word into the temp buffer, stalling while the buffer reports full.
module image_feeder_l2 #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ROW_WORDS  = 4,
  parameter int unsigned ROWS       = 3,
  parameter int unsigned ROW_STRIDE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAdr,
  input  logic              fullTemp,
  input  logic [DATA_W-1:0] dataOut,
  output logic              reMem,
  output logic [ADDR_W-1:0] adr,
  output logic [DATA_W-1:0] inpimage,
  output logic              WETemp,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WordCntW = $clog2(ROW_WORDS) + 1;
  localparam int unsigned RowCntW  = $clog2(ROWS) + 1;

  localparam logic [WordCntW-1:0] LastWord = WordCntW'(ROW_WORDS - 1);
  localparam logic [RowCntW-1:0]  LastRow  = RowCntW'(ROWS - 1);
  localparam logic [ADDR_W-1:0]   StrideA  = ADDR_W'(ROW_STRIDE);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRead    = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StPush    = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  logic [2:0]          stateQ, stateD;
  logic [ADDR_W-1:0]   baseQ, baseD;
  logic [WordCntW-1:0] wordQ, wordD;
  logic [RowCntW-1:0]  rowQ, rowD;
  logic [DATA_W-1:0]   dataQ, dataD;
  logic [ADDR_W-1:0]   rowOffset;
  logic                pushNow;

  // Counters only move after a push, so the address stays at the last read
  // value through CAPTURE, PUSH, DONE and IDLE without a separate register.
  assign rowOffset = ADDR_W'(rowQ) * StrideA;
  assign adr       = baseQ + rowOffset + ADDR_W'(wordQ);

  assign pushNow  = (stateQ == StPush) && !fullTemp;
  assign reMem    = (stateQ == StRead);
  assign WETemp   = pushNow;
  assign busy     = (stateQ != StIdle);
  assign done     = (stateQ == StDone);
  assign inpimage = dataQ;

  always_comb begin
    stateD = stateQ;
    baseD  = baseQ;
    wordD  = wordQ;
    rowD   = rowQ;
    dataD  = dataQ;
    unique case (stateQ)
      StIdle: begin
        if (start) begin
          baseD  = baseAdr;
          wordD  = '0;
          rowD   = '0;
          stateD = StRead;
        end
      end
      StRead: begin
        stateD = StCapture;
      end
      StCapture: begin
        dataD  = dataOut;
        stateD = StPush;
      end
      StPush: begin
        if (!fullTemp) begin
          if ((wordQ == LastWord) && (rowQ == LastRow)) begin
            stateD = StDone;
          end else begin
            stateD = StRead;
            if (wordQ == LastWord) begin
              wordD = '0;
              rowD  = rowQ + RowCntW'(1);
            end else begin
              wordD = wordQ + WordCntW'(1);
            end
          end
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StIdle;
      baseQ  <= '0;
      wordQ  <= '0;
      rowQ   <= '0;
      dataQ  <= '0;
    end else begin
      stateQ <= stateD;
      baseQ  <= baseD;
      wordQ  <= wordD;
      rowQ   <= rowD;
      dataQ  <= dataD;
    end
  end

endmodule

// File: tb/tb_image_feeder_l2.sv
// Directed bench for image_feeder_l2: scoreboard of expected read addresses and
// pushed words, plus cycle checks on done/busy, backpressure, wrap and reset abort.
module tb_image_feeder_l2;

  logic        clk = 1'b0;
  logic        rst, start, fullTemp;
  logic [6:0]  baseAdr;
  logic [31:0] dataOut;
  logic        reMem, WETemp, busy, done;
  logic [6:0]  adr;
  logic [31:0] inpimage;

  // Minimal-window instance (1x1)
  logic        mStart;
  logic [6:0]  mBase;
  logic [31:0] mDataOut;
  logic        mReMem, mWETemp, mBusy, mDone;
  logic [6:0]  mAdr;
  logic [31:0] mInp;

  int nVec = 0;
  int nErr = 0;
  logic [31:0] expAdr[$];
  logic [31:0] expData[$];

  always #5 clk = ~clk;

  image_feeder_l2 dut (
    .clk(clk), .rst(rst), .start(start), .baseAdr(baseAdr), .fullTemp(fullTemp),
    .dataOut(dataOut), .reMem(reMem), .adr(adr), .inpimage(inpimage), .WETemp(WETemp),
    .busy(busy), .done(done)
  );

  image_feeder_l2 #(.ROW_WORDS(1), .ROWS(1)) dutMin (
    .clk(clk), .rst(rst), .start(mStart), .baseAdr(mBase), .fullTemp(1'b0),
    .dataOut(mDataOut), .reMem(mReMem), .adr(mAdr), .inpimage(mInp), .WETemp(mWETemp),
    .busy(mBusy), .done(mDone)
  );

  // Memory model: memory[a] = a + 0x100, one-cycle read latency, junk when not read
  always @(posedge clk) begin
    dataOut  <= reMem ? (32'h100 + {25'd0, adr}) : 32'hDEAD_BEEF;
    mDataOut <= mReMem ? (32'h100 + {25'd0, mAdr}) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(inout int cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs one window. Cycle k is the clock period ending at edge k; start is
  // sampled at edge 0. Negative cycle arguments disable that stimulus.
  task automatic runXfer(input logic [6:0] base, input int stallFrom, input int stallLen,
                         input int startA, input int startB, input int rstAt,
                         input int expDone, input int expBusyFall, input int expPush);
    int cyc = 0;
    int nDone = 0;
    int nPush = 0;
    bit finished = 1'b0;
    logic [31:0] e;
    expAdr.delete();
    expData.delete();
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 4; w++) begin
        e = 32'((int'(base) + r * 8 + w) & 127);
        expAdr.push_back(e);
        expData.push_back(32'h100 + e);
      end
    end
    baseAdr = base;
    start = 1'b1;
    tick(cyc);
    start = 1'b0;
    baseAdr = 7'd50;
    while (!finished && cyc < 200) begin
      fullTemp = (cyc >= stallFrom) && (cyc < stallFrom + stallLen);
      start    = (cyc == startA) || (cyc == startB);
      rst      = (cyc == rstAt);
      #1;
      if (reMem) begin
        if (expAdr.size() == 0) check("extra_read", 32'd1, 32'd0);
        else begin
          e = expAdr.pop_front();
          check("read_adr", {25'd0, adr}, e);
        end
      end
      if (WETemp) begin
        nPush++;
        if (expData.size() == 0) check("extra_push", 32'd1, 32'd0);
        else begin
          e = expData.pop_front();
          check("push_data", inpimage, e);
        end
      end
      if (fullTemp && expData.size() > 0) begin
        check("stall_we", {31'd0, WETemp}, 32'd0);
        check("stall_hold", inpimage, expData[0]);
      end
      if (done) begin
        nDone++;
        check("done_cycle", cyc, expDone);
      end
      if (rstAt >= 0 && cyc == rstAt + 1)
        check("rst_outputs", {reMem, WETemp, busy, done, adr, inpimage[20:0]}, 32'd0);
      if (cyc > 1 && !busy) begin
        finished = 1'b1;
        check("busy_fall", cyc, expBusyFall);
      end
      if (!finished) tick(cyc);
    end
    start = 1'b0;
    fullTemp = 1'b0;
    rst = 1'b0;
    if (!finished) check("timeout", 32'd0, 32'd1);
    check("done_count", nDone, (rstAt >= 0) ? 0 : 1);
    check("push_count", nPush, expPush);
    if (rstAt < 0) check("sb_left", expData.size() + expAdr.size(), 0);
    // Stays idle afterwards: catches a start taken in DONE or a stray pulse
    for (int i = 0; i < 3; i++) begin
      tick(cyc);
      check("idle_after", {29'd0, busy, done, WETemp}, 32'd0);
    end
  endtask

  initial begin
    int mc;
    logic [31:0] mExp[5];
    rst = 1'b1;
    start = 1'b0;
    fullTemp = 1'b0;
    baseAdr = '0;
    mStart = 1'b0;
    mBase = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {reMem, WETemp, busy, done, adr, inpimage[20:0]}, 32'd0);
    check("reset_inpimage", inpimage, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic window
    runXfer(7'd0, -1, 0, -1, -1, -1, 37, 38, 12);
    // Backpressure: 5 full cycles starting at the 2nd PUSH (cycle 6)
    runXfer(7'd0, 6, 5, -1, -1, -1, 42, 43, 12);
    // Address wrap
    runXfer(7'd120, -1, 0, -1, -1, -1, 37, 38, 12);
    // Start while busy (cycles 5 and 37) is ignored
    runXfer(7'd4, -1, 0, 5, 37, -1, 37, 38, 12);
    // Reset during 4th word: 3 pushes, no done, idle in cycle 11
    runXfer(7'd0, -1, 0, -1, -1, 10, -1, 11, 3);
    // Full transfer after the abort
    runXfer(7'd16, -1, 0, -1, -1, -1, 37, 38, 12);

    // Minimal window: read in 1, push in 3, done in 4, idle in 5
    mBase = 7'd9;
    mStart = 1'b1;
    @(posedge clk);
    #1;
    mStart = 1'b0;
    mBase = 7'd0;
    mExp[0] = {29'd0, 1'b1, 1'b0, 1'b0};
    mExp[1] = 32'd0;
    mExp[2] = {29'd0, 1'b0, 1'b1, 1'b0};
    mExp[3] = {29'd0, 1'b0, 1'b0, 1'b1};
    mExp[4] = 32'd0;
    for (mc = 1; mc <= 5; mc++) begin
      check("min_rd_we_done", {29'd0, mReMem, mWETemp, mDone}, mExp[mc-1]);
      if (mReMem) check("min_adr", {25'd0, mAdr}, 32'd9);
      if (mWETemp) check("min_data", mInp, 32'h109);
      if (mc == 5) check("min_busy", {31'd0, mBusy}, 32'd0);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/image_feeder_l2.md
# image_feeder_l2

Streams a rectangular window of 32-bit image words from the layer-2 feature memory into the layer-2 temp (main) buffer. It is the producer side of the temp buffer's `inpimage`/`WETemp`/`fullTemp` write interface. The block walks row/word counters to generate memory addresses, issues synchronous reads, holds each returned word, and pushes it into the buffer only while the buffer is not full. A one-cycle `done` pulse tells the layer-2 controller that the window is loaded.

## Interface

Parameters:
- `ADDR_W`, 7, memory address width.
- `DATA_W`, 32, memory word and buffer write width.
- `ROW_WORDS`, 4, words read per window row (≥1).
- `ROWS`, 3, rows per window (≥1).
- `ROW_STRIDE`, 8, address distance between consecutive window rows.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin one window transfer; sampled only in IDLE.
- `baseAdr`  in  ADDR_W  address of the window's first word; latched when `start` is accepted.
- `fullTemp`  in  1  temp buffer full; blocks pushes.
- `dataOut`  in  DATA_W  memory read data; valid the cycle after `reMem`.
- `reMem`  out  1  memory read enable.
- `adr`  out  ADDR_W  memory read address.
- `inpimage`  out  DATA_W  word presented to the temp buffer.
- `WETemp`  out  1  temp buffer write enable.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the window has been fully pushed.

## Operation

States:
- **IDLE**
  - `start`=1: latch `baseAdr`, clear `wordCnt` and `rowCnt`, go to READ.
  - Otherwise stay in IDLE.
- **READ**
  - Drive `reMem`=1 and `adr` = latched base + `rowCnt`*ROW_STRIDE + `wordCnt`.
  - The sum is truncated to ADDR_W bits, so addresses wrap modulo 2^ADDR_W.
  - Go to CAPTURE.
- **CAPTURE**
  - Register `dataOut` into the data holding register (`dataReg`).
  - Go to PUSH.
- **PUSH**
  - `inpimage` = `dataReg` throughout the state.
  - `WETemp` = !`fullTemp`, combinational.
  - `fullTemp`=1: stay in PUSH, nothing changes.
  - `fullTemp`=0: the word is written this cycle. Then:
    - If this was the last word (`wordCnt`=ROW_WORDS-1 and `rowCnt`=ROWS-1), go to DONE.
    - Otherwise advance `wordCnt`. On wrap to 0, increment `rowCnt`. Go to READ.
- **DONE**
  - `done`=1 for this cycle, then go to IDLE.

Rules:
- Words are pushed in row-major order. Exactly ROW_WORDS*ROWS writes happen per transfer; none is dropped or duplicated.
- `start` is ignored outside IDLE, including in DONE.
- `inpimage` keeps the last pushed value after the transfer. It is 0 after reset.
- Counter widths: `wordCnt` is $clog2(ROW_WORDS)+1 bits and `rowCnt` is $clog2(ROWS)+1 bits. The address product is computed at ADDR_W bits.

## Timing

- Reset values: `reMem`=0, `adr`=0, `inpimage`=0, `WETemp`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- `rst` asserted mid-transfer aborts it: no further `WETemp` or `done` pulse, and the block is back in IDLE the next cycle.
- `start` sampled at edge 0 gives:
  - READ in cycle 1, CAPTURE in cycle 2, PUSH in cycle 3.
- With no stalls each word takes 3 cycles. For N = ROW_WORDS*ROWS:
  - The last `WETemp` is in cycle 3N.
  - `done` is in cycle 3N+1.
  - IDLE is reached in cycle 3N+2.
- Each cycle that `fullTemp` is high during PUSH delays all later events by one cycle.
- `fullTemp` outside PUSH has no effect.
- `reMem` is high only in READ. `WETemp` is high only in PUSH, and at most one cycle per word.
- `adr` holds its last value outside READ. Memory is read only when `reMem`=1.

## Test plan

- **Basic window:** defaults, `baseAdr`=0, `fullTemp`=0, memory[a]=a+0x100.
  - Read addresses must be 0,1,2,3,8,9,10,11,16,17,18,19.
  - 12 `WETemp` pulses carry 0x100,0x101,…,0x113 in that address order.
  - `done` is a single pulse in cycle 37.
- **Backpressure:** same stimulus, `fullTemp`=1 for 5 cycles starting at the 2nd PUSH.
  - `inpimage` holds 0x101 with `WETemp`=0 throughout the stall.
  - The word is pushed exactly once when `fullTemp` drops.
  - `done` arrives in cycle 42.
- **Address wrap:** `baseAdr`=120.
  - Addresses must be 120,121,122,123,0,1,2,3,8,9,10,11.
- **Start while busy:** pulse `start` with `baseAdr`=50 during cycles 5 and 37.
  - Both pulses are ignored.
  - Exactly 12 pushes happen from the first window's base.
  - `busy` falls in cycle 38.
- **Reset mid-op:** assert `rst` in cycle 10 (during the 4th word).
  - From cycle 11 all outputs are 0 and the block is in IDLE; no `done`.
  - A new `start` then produces a full, correct 12-word transfer.
- **Minimal window:** ROW_WORDS=1, ROWS=1.
  - One read, one push, `done` in cycle 4.
